pixel_frame_loader: RTL and testbench

- Upstream stage of the recognition datapath's bit-plane register bank.
- Accepts a raster-ordered 8-bit grayscale pixel stream through a valid/ready handshake and binarises each pixel against a threshold.
- Assembles a WIDTH x HEIGHT bit-plane and presents it, held stable, to the downstream flip-flop bank and classifier until that consumer acknowledges it.

---
 rtl/pixel_frame_loader.sv | 97 +++++++++
 tb/tb_pixel_frame_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_loader.sv
// Binarising frame loader: accepts a raster pixel stream, thresholds each pixel and
// holds the assembled WIDTH x HEIGHT bit-plane until the consumer acknowledges it.
module pixel_frame_loader #(
   parameter int WIDTH  = 28,
   parameter int HEIGHT = 28,
   parameter int THRESH = 128
) (
   input  logic                      Clock,
   input  logic                      Clr_n,
   input  logic [7:0]                Pix_data,
   input  logic                      Pix_valid,
   input  logic                      Pix_last,
   output logic                      Pix_ready,
   output logic [WIDTH*HEIGHT-1:0]   Frame_bits,
   output logic                      Frame_valid,
   input  logic                      Frame_ack,
   output logic [9:0]                Pix_cnt,
   output logic                      Err_len
);

   localparam int NPIX  = WIDTH * HEIGHT;
   localparam int COL_W = $clog2(WIDTH + 1);
   localparam int ROW_W = $clog2(HEIGHT + 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
   localparam logic [7:0]       THRESH_B = 8'(THRESH);

   // Pix_cnt is 10 bits wide and the threshold is compared against 8-bit pixels.
   generate
      if (NPIX > 1023 || NPIX < 1 || THRESH < 0 || THRESH > 255) begin : g_param_err
         $error("pixel_frame_loader: WIDTH*HEIGHT must be 1..1023 and THRESH 0..255");
      end
   endgenerate

   typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;

   state_t             state_reg;
   logic [ROW_W-1:0]   row_reg;
   logic [COL_W-1:0]   col_reg;
   logic               accept;
   logic               at_final;

   assign accept   = Pix_valid && Pix_ready;
   assign at_final = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

   always_ff @(posedge Clock or negedge Clr_n) begin
      if (!Clr_n) begin
         state_reg   <= LOAD;
         row_reg     <= '0;
         col_reg     <= '0;
         Pix_cnt     <= '0;
         Frame_bits  <= '0;
         Frame_valid <= 1'b0;
         Err_len     <= 1'b0;
         Pix_ready   <= 1'b1;
      end else begin
         case (state_reg)
            LOAD: begin
               if (accept) begin
                  // Pix_cnt always equals row*WIDTH+col, so it doubles as the write index.
                  Frame_bits[Pix_cnt] <= (Pix_data >= THRESH_B);
                  Pix_cnt <= Pix_cnt + 10'd1;
                  if (col_reg == COL_LAST) begin
                     col_reg <= '0;
                     row_reg <= row_reg + 1'b1;
                  end else begin
                     col_reg <= col_reg + 1'b1;
                  end
                  if (at_final || Pix_last) begin
                     state_reg   <= HOLD;
                     Frame_valid <= 1'b1;
                     Pix_ready   <= 1'b0;
                     // Error when Pix_last and the final index disagree.
                     Err_len     <= at_final ^ Pix_last;
                  end
               end
            end
            HOLD: begin
               if (Frame_ack) begin
                  state_reg   <= LOAD;
                  row_reg     <= '0;
                  col_reg     <= '0;
                  Pix_cnt     <= '0;
                  Frame_bits  <= '0;
                  Frame_valid <= 1'b0;
                  Err_len     <= 1'b0;
                  Pix_ready   <= 1'b1;
               end
            end
            default: begin
               state_reg <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader: full frame, threshold/row-wrap, early end,
// hold behaviour, random gaps and asynchronous reset.
module tb_pixel_frame_loader;

   localparam int WIDTH  = 28;
   localparam int HEIGHT = 28;
   localparam int NPIX   = WIDTH * HEIGHT;

   logic              Clock;
   logic              Clr_n;
   logic [7:0]        Pix_data;
   logic              Pix_valid;
   logic              Pix_last;
   logic              Pix_ready;
   logic [NPIX-1:0]   Frame_bits;
   logic              Frame_valid;
   logic              Frame_ack;
   logic [9:0]        Pix_cnt;
   logic              Err_len;

   int checks = 0;
   int errors = 0;

   logic [NPIX-1:0]   exp_bits;
   logic [NPIX-1:0]   held_bits;
   logic [7:0]        d;

   pixel_frame_loader #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .THRESH(128)) dut (
      .Clock       (Clock),
      .Clr_n       (Clr_n),
      .Pix_data    (Pix_data),
      .Pix_valid   (Pix_valid),
      .Pix_last    (Pix_last),
      .Pix_ready   (Pix_ready),
      .Frame_bits  (Frame_bits),
      .Frame_valid (Frame_valid),
      .Frame_ack   (Frame_ack),
      .Pix_cnt     (Pix_cnt),
      .Err_len     (Err_len)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus; returns #1 after the sampling edge.
   task automatic push(input logic [7:0] data, input logic last, input logic valid);
      Pix_data  = data;
      Pix_last  = last;
      Pix_valid = valid;
      @(posedge Clock);
      #1;
      Pix_valid = 1'b0;
      Pix_last  = 1'b0;
   endtask

   task automatic ack_frame();
      Frame_ack = 1'b1;
      @(posedge Clock);
      #1;
      Frame_ack = 1'b0;
   endtask

   initial begin
      Clr_n = 1'b0; Pix_data = 8'd0; Pix_valid = 1'b0; Pix_last = 1'b0; Frame_ack = 1'b0;
      #12;
      check("rst_ready", Pix_ready, 1'b1);
      check("rst_fvalid", Frame_valid, 1'b0);
      check("rst_cnt", Pix_cnt, 10'd0);
      check("rst_err", Err_len, 1'b0);
      check("rst_bits", Frame_bits, '0);
      Clr_n = 1'b1;
      @(posedge Clock);
      #1;

      // Full frame, alternating 200/50, Pix_last on the final pixel.
      for (int i = 0; i < NPIX; i++) begin
         push((i % 2 == 0) ? 8'd200 : 8'd50, (i == NPIX - 1), 1'b1);
         if (i == NPIX - 2) check("full_not_yet_valid", Frame_valid, 1'b0);
      end
      check("full_fvalid", Frame_valid, 1'b1);
      check("full_bits", Frame_bits, {392{2'b01}});
      check("full_cnt", Pix_cnt, 10'd784);
      check("full_err", Err_len, 1'b0);
      check("full_ready", Pix_ready, 1'b0);
      ack_frame();
      check("ack1_fvalid", Frame_valid, 1'b0);
      check("ack1_bits", Frame_bits, '0);
      check("ack1_ready", Pix_ready, 1'b1);
      check("ack1_cnt", Pix_cnt, 10'd0);

      // Threshold edges, row wrap, stray ack in LOAD, early end at pixel 100.
      exp_bits = '0;
      exp_bits[1] = 1'b1;
      exp_bits[2] = 1'b1;
      exp_bits[28] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         case (i)
            0:       d = 8'd127;
            1:       d = 8'd128;
            2:       d = 8'd255;
            28:      d = 8'd255;
            default: d = 8'd0;
         endcase
         Frame_ack = (i == 50);
         push(d, (i == 99), 1'b1);
         Frame_ack = 1'b0;
         if (i == 50) check("ack_in_load_cnt", Pix_cnt, 10'd51);
      end
      check("early_fvalid", Frame_valid, 1'b1);
      check("early_cnt", Pix_cnt, 10'd100);
      check("early_err", Err_len, 1'b1);
      check("thresh_bits", Frame_bits, exp_bits);
      check("thresh_bit28", Frame_bits[28], 1'b1);

      // Hold: pixels offered for 10 cycles must be ignored.
      held_bits = Frame_bits;
      for (int i = 0; i < 10; i++) push(8'd255, 1'b0, 1'b1);
      check("hold_cnt", Pix_cnt, 10'd100);
      check("hold_bits", Frame_bits, exp_bits);
      check("hold_ready", Pix_ready, 1'b0);
      Pix_valid = 1'b1; Pix_data = 8'd255;
      ack_frame();
      Pix_valid = 1'b1;
      check("ack2_fvalid", Frame_valid, 1'b0);
      check("ack2_bits", Frame_bits, '0);
      check("ack2_err", Err_len, 1'b0);
      check("ack2_ready", Pix_ready, 1'b1);
      check("ack2_cnt", Pix_cnt, 10'd0);
      push(8'd255, 1'b0, 1'b1);
      check("next_first_cnt", Pix_cnt, 10'd1);
      check("next_first_bits", Frame_bits, {{(NPIX-1){1'b0}}, 1'b1});

      // Load up to 300 pixels, then pulse reset between edges.
      for (int i = 1; i < 300; i++) push((i % 3 == 0) ? 8'd200 : 8'd10, 1'b0, 1'b1);
      check("pre_rst_cnt", Pix_cnt, 10'd300);
      #2 Clr_n = 1'b0;
      #1;
      check("async_rst_cnt", Pix_cnt, 10'd0);
      check("async_rst_bits", Frame_bits, '0);
      check("async_rst_ready", Pix_ready, 1'b1);
      check("async_rst_fvalid", Frame_valid, 1'b0);
      #1 Clr_n = 1'b1;
      @(posedge Clock);
      #1;

      // Random gaps, no Pix_last: normal completion with length error.
      exp_bits = '0;
      for (int i = 0; i < NPIX; i++) begin
         while ($urandom_range(0, 1) == 1) push(8'($urandom_range(0, 255)), 1'b0, 1'b0);
         d = 8'($urandom_range(0, 255));
         exp_bits[i] = (d >= 8'd128);
         push(d, 1'b0, 1'b1);
      end
      check("rand_fvalid", Frame_valid, 1'b1);
      check("rand_ready", Pix_ready, 1'b0);
      check("rand_cnt", Pix_cnt, 10'd784);
      check("rand_err", Err_len, 1'b1);
      check("rand_bits", Frame_bits, exp_bits);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
